// File: rtl/cam_capture_fsm_pkg.sv
// Shared definitions for the OV7670 capture stage: state encoding, default
// frame geometry and the RGB565 -> RGB332 pixel packer.
package cam_capture_fsm_pkg;

  // 2-bit state codes, also used as the enum values below
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_BYTE1      = 2'd2;
  localparam logic [1:0] ST_BYTE2      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE       = ST_IDLE,
    S_WAIT_FRAME = ST_WAIT_FRAME,
    S_BYTE1      = ST_BYTE1,
    S_BYTE2      = ST_BYTE2
  } cap_state_t;

  // Default geometry (QQVGA)
  localparam int DEF_IMG_W    = 160;
  localparam int DEF_IMG_H    = 120;
  localparam int FRAME_PIXELS = DEF_IMG_W * DEF_IMG_H;

  // First byte carries R[4:0],G[5:3]; second byte carries G[2:0],B[4:0].
  // Keep the top 3 bits of R, the top 3 bits of G and the top 2 bits of B.
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] byte1,
                                                  input logic [7:0] byte2);
    return {byte1[7:5], byte1[2:0], byte2[4:3]};
  endfunction

endpackage

// File: rtl/cam_capture_fsm.sv
// OV7670 pixel capture: waits for the start of a frame (vsync falling),
// pairs href-qualified bytes into RGB565 pixels, packs them to RGB332 and
// writes them with a linear address. Signals frame_done at vsync rising.
module cam_capture_fsm
  import cam_capture_fsm_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW    = 15
) (
  input  logic          pclk,
  input  logic          in_reset,
  input  logic          enable,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          frame_done
);

  localparam logic [AW-1:0] LP_LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [AW-1:0] LP_ADDR_ONE  = AW'(1);

  cap_state_t    r_state;
  logic          r_vsync_q;
  logic [7:0]    r_byte1;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_px_data;
  logic          r_px_wr;
  logic          r_frame_done;
  logic          r_full;

  cap_state_t    w_state_nxt;
  logic [7:0]    w_byte1_nxt;
  logic [7:0]    w_px_data_nxt;
  logic          w_px_wr_nxt;
  logic          w_frame_done_nxt;
  logic          w_addr_clr;
  logic          w_vs_rise;
  logic          w_vs_fall;
  logic          w_at_last;

  assign w_vs_rise = vsync & ~r_vsync_q;
  assign w_vs_fall = ~vsync & r_vsync_q;
  assign w_at_last = (r_addr == LP_LAST_ADDR);

  // State register
  always_ff @(posedge pclk) begin
    if (in_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; frame end wins over href
  always_comb begin
    w_state_nxt      = r_state;
    w_byte1_nxt      = r_byte1;
    w_px_data_nxt    = r_px_data;
    w_px_wr_nxt      = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_addr_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_WAIT_FRAME;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_FRAME: begin
        if (w_vs_fall) begin
          w_state_nxt = S_BYTE1;
          w_addr_clr  = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_FRAME;
        end
      end
      S_BYTE1: begin
        if (w_vs_rise) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = enable ? S_WAIT_FRAME : S_IDLE;
        end else if (href) begin
          w_byte1_nxt = px_data;
          w_state_nxt = S_BYTE2;
        end else begin
          w_state_nxt = S_BYTE1;
        end
      end
      S_BYTE2: begin
        if (w_vs_rise) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = enable ? S_WAIT_FRAME : S_IDLE;
        end else if (href) begin
          // Once the last address has been written, drop the rest of the frame
          if (!r_full) begin
            w_px_wr_nxt   = 1'b1;
            w_px_data_nxt = rgb565_to_rgb332(r_byte1, px_data);
          end else begin
            w_px_wr_nxt   = 1'b0;
          end
          w_state_nxt = S_BYTE1;
        end else begin
          // Orphan first byte: href dropped mid-pair, nothing is written
          w_state_nxt = S_BYTE1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs, vsync history and first-byte holding register
  always_ff @(posedge pclk) begin
    if (in_reset) begin
      r_vsync_q    <= 1'b0;
      r_byte1      <= 8'h00;
      r_px_data    <= 8'h00;
      r_px_wr      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_vsync_q    <= vsync;
      r_byte1      <= w_byte1_nxt;
      r_px_data    <= w_px_data_nxt;
      r_px_wr      <= w_px_wr_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Write address: cleared at frame start, advanced after each write, held at the last pixel
  always_ff @(posedge pclk) begin
    if (in_reset) begin
      r_addr <= '0;
      r_full <= 1'b0;
    end else if (w_addr_clr) begin
      r_addr <= '0;
      r_full <= 1'b0;
    end else if (r_px_wr) begin
      if (w_at_last) begin
        r_full <= 1'b1;
      end else begin
        r_addr <= r_addr + LP_ADDR_ONE;
      end
    end
  end

  assign mem_px_addr = r_addr;
  assign mem_px_data = r_px_data;
  assign px_wr       = r_px_wr;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_cam_capture_fsm.sv
// Self-checking bench for cam_capture_fsm: a scoreboard queue of expected
// (address, pixel) writes, a vector table for pixel packing, and
// hand-written sequences for frame boundaries, enable changes and reset.
module tb_cam_capture_fsm;

  localparam int AW     = 15;
  localparam int NPIX   = 160 * 120;
  localparam int NVEC   = 7;

  logic          pclk;
  logic          in_reset;
  logic          enable;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;
  logic          frame_done;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb_q [$];

  int n_checks  = 0;
  int n_errors  = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  int last_addr = -1;

  cam_capture_fsm #(.IMG_W(160), .IMG_H(120), .AW(AW)) dut (
    .pclk        (pclk),
    .in_reset    (in_reset),
    .enable      (enable),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // Reference packing written with masks and shifts
  function automatic logic [7:0] exp_pack(input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] r;
    r = (b1 & 8'hE0) | ((b1 & 8'h07) << 2) | ((b2 >> 3) & 8'h03);
    return r;
  endfunction

  function automatic void push(input int addr, input logic [7:0] data);
    exp_t e;
    e.addr = AW'(addr);
    e.data = data;
    sb_q.push_back(e);
  endfunction

  // Output monitor: compares every write against the scoreboard
  always @(negedge pclk) begin
    exp_t e;
    if (px_wr) begin
      wr_cnt++;
      last_addr = int'(mem_px_addr);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", mem_px_addr, mem_px_data);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", int'(mem_px_addr), int'(e.addr));
        chk("wr_data", int'(mem_px_data), int'(e.data));
      end
    end
    if (frame_done) done_cnt++;
    if (px_wr && frame_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL wr_and_done: got px_wr=1 frame_done=1 expected never both");
    end
  end

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
    vsync   = vs;
    href    = hr;
    px_data = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(vsync, 1'b0, 8'h00);
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_pair(input logic [7:0] b1, input logic [7:0] b2);
    drive(1'b0, 1'b1, b1);
    drive(1'b0, 1'b1, b2);
  endtask

  task automatic drain(input string name);
    idle(4);
    chk(name, sb_q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"}, int'(mem_px_addr), 0);
    chk({tag, "_data"}, int'(mem_px_data), 0);
    chk({tag, "_px_wr"}, int'(px_wr), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int d0;
    logic [7:0] b1;
    logic [7:0] b2;

    vecs[0] = '{b1: 8'h07, b2: 8'hE0, exp: 8'h1C};
    vecs[1] = '{b1: 8'h00, b2: 8'h1F, exp: 8'h03};
    vecs[2] = '{b1: 8'hF8, b2: 8'h00, exp: 8'hE0};
    vecs[3] = '{b1: 8'hFF, b2: 8'hFF, exp: 8'hFF};
    vecs[4] = '{b1: 8'hA5, b2: 8'h5A, exp: 8'hB7};
    vecs[5] = '{b1: 8'h3C, b2: 8'hC3, exp: 8'h30};
    vecs[6] = '{b1: 8'h18, b2: 8'h08, exp: 8'h01};

    in_reset = 1'b1;
    enable   = 1'b0;
    vsync    = 1'b0;
    href     = 1'b0;
    px_data  = 8'h00;
    idle(3);
    chk_zero_outputs("reset");
    in_reset = 1'b0;

    // Test 1: first pixel of a frame
    enable = 1'b1;
    idle(2);
    start_frame();
    push(0, 8'hE0);
    send_pair(8'hF8, 8'h00);
    drain("t1_drain");
    d0 = done_cnt;
    end_frame();
    chk("t1_frame_done", done_cnt - d0, 1);

    // Test 2: packing vector table, addresses from 0
    start_frame();
    for (int i = 0; i < NVEC; i++) begin
      push(i, vecs[i].exp);
      send_pair(vecs[i].b1, vecs[i].b2);
    end
    drain("t2_drain");

    // Test 3: orphan byte dropped, next pair written at the next address
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b0, 8'h00);
    push(NVEC, 8'h03);
    send_pair(8'h00, 8'h18);
    drain("t3_drain");

    // vsync rise with href and a pending first byte: no write, frame_done
    w0 = wr_cnt;
    d0 = done_cnt;
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b1, 1'b1, 8'hBB);
    idle(3);
    chk("prio_no_write", wr_cnt - w0, 0);
    chk("prio_frame_done", done_cnt - d0, 1);

    // Test 4: full frame plus 10 surplus pairs
    start_frame();
    w0 = wr_cnt;
    d0 = done_cnt;
    for (int p = 0; p < NPIX + 10; p++) begin
      b1 = p[7:0];
      b2 = p[15:8] ^ 8'h5A;
      if (p < NPIX) push(p, exp_pack(b1, b2));
      send_pair(b1, b2);
    end
    drain("t4_drain");
    chk("t4_write_count", wr_cnt - w0, NPIX);
    chk("t4_last_addr", last_addr, NPIX - 1);
    chk("t4_no_early_done", done_cnt - d0, 0);
    end_frame();
    chk("t4_frame_done", done_cnt - d0, 1);

    // Test 5a: enable drops mid-frame, frame still completes
    start_frame();
    push(0, exp_pack(8'hA5, 8'h5A));
    send_pair(8'hA5, 8'h5A);
    enable = 1'b0;
    push(1, exp_pack(8'h3C, 8'hC3));
    send_pair(8'h3C, 8'hC3);
    drain("t5a_drain");
    d0 = done_cnt;
    end_frame();
    chk("t5a_frame_done", done_cnt - d0, 1);

    // Test 5b: idle frame, then enable rises mid-frame: nothing until next vs_fall
    w0 = wr_cnt;
    d0 = done_cnt;
    start_frame();
    send_pair(8'h11, 8'h22);
    enable = 1'b1;
    send_pair(8'h33, 8'h44);
    send_pair(8'h55, 8'h66);
    end_frame();
    chk("t5b_no_write", wr_cnt - w0, 0);
    chk("t5b_no_done", done_cnt - d0, 0);

    // Test 6: 50 pixels, reset mid-frame, then restart from address 0
    start_frame();
    for (int p = 0; p < 50; p++) begin
      b1 = 8'(p * 5);
      b2 = 8'(p * 3 + 1);
      push(p, exp_pack(b1, b2));
      send_pair(b1, b2);
    end
    drain("t6_drain");
    in_reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    chk_zero_outputs("t6_reset");
    in_reset = 1'b0;
    w0 = wr_cnt;
    d0 = done_cnt;
    send_pair(8'h77, 8'h88);
    send_pair(8'h99, 8'hAA);
    idle(2);
    chk("t6_wait_vs_fall", wr_cnt - w0, 0);
    end_frame();
    chk("t6_no_done", done_cnt - d0, 0);
    start_frame();
    push(0, 8'h30);
    send_pair(8'h3C, 8'hC3);
    drain("t6_restart_drain");
    end_frame();
    chk("t6_frame_done", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
